// File: rtl/deck_pkg.sv
// Shared types, constants and LFSR step function for the deck
// randomization blocks.
package deck_pkg;

    localparam int          DECK_SIZE = 52;
    localparam int          ADDR_W    = 6;
    localparam int          DATA_W    = 7;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        IDLE,
        PICK,
        RD_I,
        RD_J,
        CAP_J,
        WR_I,
        WR_J,
        DONE
    } shuf_state_t;

    // Galois step for x^16+x^14+x^13+x^11+1. The button level is folded
    // into bit 0, and the all-zero lock-up state is replaced by the seed.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur,
                                              input logic        ent,
                                              input logic [15:0] seed);
        logic [15:0] nxt;
        nxt    = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_MASK : 16'h0000);
        nxt[0] = nxt[0] ^ ent;
        return (nxt == 16'h0000) ? seed : nxt;
    endfunction

endpackage

// File: rtl/deck_shuffler_lfsr16.sv
// Free-running 16-bit Galois LFSR with an entropy input; shared by any
// block that needs cheap randomness.
module lfsr16
    import deck_pkg::*;
#(
    parameter logic [15:0] SEED = deck_pkg::LFSR_SEED
) (
    input  logic        outclk,
    input  logic        sync_rst,
    input  logic        entropy_bit,
    output logic [15:0] q
);

    always_ff @(posedge outclk or posedge sync_rst) begin
        if (sync_rst) begin
            q <= SEED;
        end else begin
            q <= lfsr_step(q, entropy_bit, SEED);
        end
    end

endmodule

// File: rtl/deck_shuffler.sv
// In-place Fisher-Yates shuffle of deck_memory, run once after the loader
// finishes and before card_draw takes the memory port.
module deck_shuffler #(
    parameter int          DECK_SIZE = deck_pkg::DECK_SIZE,
    parameter int          ADDR_W    = deck_pkg::ADDR_W,
    parameter int          DATA_W    = deck_pkg::DATA_W,
    parameter logic [15:0] SEED      = deck_pkg::LFSR_SEED
) (
    input  logic              outclk,
    input  logic              sync_rst,
    input  logic              load_done,
    input  logic              entropy_bit,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              deck_ready
);

    import deck_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(DECK_SIZE - 1);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

    shuf_state_t         state;
    shuf_state_t         state_nxt;
    logic [ADDR_W-1:0]   i;
    logic [ADDR_W-1:0]   j;
    logic [ADDR_W-1:0]   j_pick;
    logic [DATA_W-1:0]   cap_i;
    logic [DATA_W-1:0]   cap_j;
    logic [15:0]         lfsr_q;
    logic [2*ADDR_W-1:0] pick_prod;
    logic                lfsr_unused;

    lfsr16 #(
        .SEED(SEED)
    ) u_lfsr (
        .outclk     (outclk),
        .sync_rst   (sync_rst),
        .entropy_bit(entropy_bit),
        .q          (lfsr_q)
    );

    // Scaling r in [0,63] by (i+1) and keeping the top half of the product
    // lands j in [0,i] without a divider or a rejection loop.
    assign pick_prod   = {{ADDR_W{1'b0}}, lfsr_q[ADDR_W-1:0]}
                       * ({{ADDR_W{1'b0}}, i} + (2*ADDR_W)'(1));
    assign j_pick      = pick_prod[2*ADDR_W-1:ADDR_W];
    assign lfsr_unused = ^lfsr_q[15:ADDR_W];

    always_ff @(posedge outclk or posedge sync_rst) begin
        if (sync_rst) begin
            state <= IDLE;
            i     <= LAST_I;
            j     <= '0;
            cap_i <= '0;
            cap_j <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE:    if (load_done) i <= LAST_I;
                PICK:    j <= j_pick;
                RD_J:    cap_i <= mem_rdata;
                CAP_J:   cap_j <= mem_rdata;
                WR_J:    if (i != ONE) i <= i - ONE;
                default: ;
            endcase
        end
    end

    // Read data lags the address by one cycle, so RD_J captures word i and
    // CAP_J captures word j.
    always_comb begin
        state_nxt  = state;
        mem_addr   = '0;
        mem_wen    = 1'b0;
        mem_wdata  = '0;
        busy       = 1'b1;
        deck_ready = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (load_done) state_nxt = PICK;
            end
            PICK: state_nxt = RD_I;
            RD_I: begin
                mem_addr  = i;
                state_nxt = RD_J;
            end
            RD_J: begin
                mem_addr  = j;
                state_nxt = CAP_J;
            end
            CAP_J: state_nxt = WR_I;
            WR_I: begin
                mem_addr  = i;
                mem_wen   = 1'b1;
                mem_wdata = cap_j;
                state_nxt = WR_J;
            end
            WR_J: begin
                mem_addr  = j;
                mem_wen   = 1'b1;
                mem_wdata = cap_i;
                state_nxt = (i == ONE) ? DONE : PICK;
            end
            DONE: begin
                busy       = 1'b0;
                deck_ready = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_deck_shuffler.sv
// Directed/randomized bench for deck_shuffler with a behavioural deck model
// and a bench-owned deck_memory behind the three-way port mux.
module tb_deck_shuffler;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          N    = 52;

    logic       outclk = 1'b0;
    logic       sync_rst;
    logic       load_done;
    logic       entropy_bit;
    logic [5:0] mem_addr;
    logic       mem_wen;
    logic [6:0] mem_wdata;
    logic [6:0] mem_rdata;
    logic       busy;
    logic       deck_ready;

    deck_shuffler #(
        .DECK_SIZE(N),
        .ADDR_W   (6),
        .DATA_W   (7),
        .SEED     (SEED)
    ) dut (
        .outclk     (outclk),
        .sync_rst   (sync_rst),
        .load_done  (load_done),
        .entropy_bit(entropy_bit),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .deck_ready (deck_ready)
    );

    always #5 outclk = ~outclk;

    // deck_memory and its owner mux: loader, shuffler, then an idle card_draw
    logic       ld_wen;
    logic [5:0] ld_addr;
    logic [6:0] ld_wdata;
    logic [6:0] mem [0:63];
    logic [5:0] m_addr;
    logic       m_wen;
    logic [6:0] m_wdata;

    always_comb begin
        m_addr  = '0;
        m_wen   = 1'b0;
        m_wdata = '0;
        if (!load_done) begin
            m_addr  = ld_addr;
            m_wen   = ld_wen;
            m_wdata = ld_wdata;
        end else if (!deck_ready) begin
            m_addr  = mem_addr;
            m_wen   = mem_wen;
            m_wdata = mem_wdata;
        end
    end

    always @(posedge outclk) begin
        if (m_wen) mem[m_addr] <= m_wdata;
        mem_rdata <= mem[m_addr];
    end

    logic [15:0] m_lfsr;
    int          m_deck [N];
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_chk  = 0;

    function automatic logic [15:0] ref_next(input logic [15:0] v, input logic e);
        logic [15:0] r;
        r    = (v >> 1) ^ ((v % 2 == 1) ? 16'hB400 : 16'h0000);
        r[0] = r[0] ^ e;
        if (r == 16'h0000) r = SEED;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic e);
        entropy_bit = e;
        @(posedge outclk);
        m_lfsr = ref_next(m_lfsr, e);
        @(negedge outclk);
    endtask

    task automatic check_deck(input string tag);
        int mism;
        int missing;
        int seen [N];
        mism    = 0;
        missing = 0;
        for (int k = 0; k < N; k++) seen[k] = 0;
        for (int k = 0; k < N; k++) begin
            if (32'(mem[k]) !== 32'(m_deck[k])) mism++;
            if (int'(mem[k]) < N) seen[int'(mem[k])]++;
        end
        for (int k = 0; k < N; k++) if (seen[k] != 1) missing++;
        check({tag, "_model"}, 32'(mism), 32'd0);
        check({tag, "_perm"}, 32'(missing), 32'd0);
    endtask

    // mode 0: entropy 0; 1: random; 2: first pick forced to r=63, then random.
    // abort_at >= 0 asserts reset just after that edge.
    task automatic run_shuffle(input int mode, input int abort_at);
        int  i_m;
        int  j_m;
        int  c;
        int  tmp;
        bit  stop;
        logic e;
        stop = 1'b0;
        j_m  = 0;
        for (int n = 0; n <= 306 && !stop; n++) begin
            if (mode == 0)                e = 1'b0;
            else if (mode == 2 && n == 0) e = ~m_lfsr[1];
            else                          e = 1'($urandom_range(0, 1));
            tick(e);
            if (n == 306) begin
                check("ready_at_307th_edge", 32'(deck_ready), 32'd1);
                check("busy_done", 32'(busy), 32'd0);
                check("wen_done", 32'(mem_wen), 32'd0);
                check("addr_done", 32'(mem_addr), 32'd0);
            end else begin
                c   = n % 6;
                i_m = (N - 1) - n / 6;
                if (c == 0) j_m = (int'(m_lfsr[5:0]) * (i_m + 1)) >> 6;
                check("busy_run", 32'(busy), 32'd1);
                check("ready_run", 32'(deck_ready), 32'd0);
                case (c)
                    1: begin
                        check("rd_i_addr", 32'(mem_addr), 32'(i_m));
                        check("rd_i_wen", 32'(mem_wen), 32'd0);
                    end
                    2: begin
                        check("rd_j_addr", 32'(mem_addr), 32'(j_m));
                        check("j_le_i", 32'(int'(mem_addr) <= i_m), 32'd1);
                        check("rd_j_wen", 32'(mem_wen), 32'd0);
                        if (mode == 2 && n == 2) check("forced_j", 32'(mem_addr), 32'd51);
                    end
                    4: begin
                        check("wr_i_wen", 32'(mem_wen), 32'd1);
                        check("wr_i_addr", 32'(mem_addr), 32'(i_m));
                        check("wr_i_data", 32'(mem_wdata), 32'(m_deck[j_m]));
                    end
                    5: begin
                        check("wr_j_wen", 32'(mem_wen), 32'd1);
                        check("wr_j_addr", 32'(mem_addr), 32'(j_m));
                        check("wr_j_data", 32'(mem_wdata), 32'(m_deck[i_m]));
                        tmp         = m_deck[i_m];
                        m_deck[i_m] = m_deck[j_m];
                        m_deck[j_m] = tmp;
                    end
                    default: check("nowrite_wen", 32'(mem_wen), 32'd0);
                endcase
                if (n == abort_at) begin
                    #2 sync_rst = 1'b1;
                    #1;
                    check("abort_wen", 32'(mem_wen), 32'd0);
                    check("abort_busy", 32'(busy), 32'd0);
                    check("abort_ready", 32'(deck_ready), 32'd0);
                    check("abort_addr", 32'(mem_addr), 32'd0);
                    m_lfsr = SEED;
                    stop   = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int   w;
        int   saved51;
        int   deck_before [N];
        sync_rst    = 1'b1;
        load_done   = 1'b0;
        entropy_bit = 1'b0;
        ld_wen      = 1'b0;
        ld_addr     = '0;
        ld_wdata    = '0;
        repeat (2) @(negedge outclk);

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(deck_ready), 32'd0);
        check("rst_wen", 32'(mem_wen), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_lfsr", 32'(dut.lfsr_q), 32'(SEED));
        m_lfsr   = SEED;
        sync_rst = 1'b0;

        // idle with load_done low while the loader fills the deck
        for (int k = 0; k < 100; k++) begin
            ld_wen   = (k < N);
            ld_addr  = 6'(k);
            ld_wdata = 7'(k);
            tick(1'($urandom_range(0, 1)));
            if (k == 0) check("lfsr_first_step", 32'(dut.lfsr_q), 32'(m_lfsr));
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_ready", 32'(deck_ready), 32'd0);
            check("idle_wen", 32'(mem_wen), 32'd0);
            check("idle_addr", 32'(mem_addr), 32'd0);
        end
        ld_wen = 1'b0;
        check("lfsr_after_idle", 32'(dut.lfsr_q), 32'(m_lfsr));
        for (int k = 0; k < N; k++) m_deck[k] = k;
        check_deck("loaded");

        load_done = 1'b1;
        run_shuffle(0, -1);
        check_deck("run1");

        // terminal state must ignore load_done and button activity
        for (int k = 0; k < N; k++) deck_before[k] = m_deck[k];
        for (int k = 0; k < 500; k++) begin
            load_done = 1'($urandom_range(0, 1));
            tick(1'($urandom_range(0, 1)));
            check("done_ready", 32'(deck_ready), 32'd1);
            check("done_wen", 32'(mem_wen), 32'd0);
            check("done_busy", 32'(busy), 32'd0);
        end
        for (int k = 0; k < N; k++) m_deck[k] = deck_before[k];
        check_deck("after_done");

        // rerun with the first pick forced to j == i == 51
        load_done = 1'b0;
        sync_rst  = 1'b1;
        @(negedge outclk);
        check("rst2_ready", 32'(deck_ready), 32'd0);
        m_lfsr   = SEED;
        sync_rst = 1'b0;
        w        = 0;
        while (m_lfsr[6:2] != 5'h1F && w < 2000) begin
            tick(1'($urandom_range(0, 1)));
            w++;
        end
        check("steer_window_found", 32'(w < 2000), 32'd1);
        saved51   = m_deck[51];
        load_done = 1'b1;
        run_shuffle(2, -1);
        check("loc51_unchanged", 32'(mem[51]), 32'(saved51));
        check_deck("run2");

        // load_done high out of reset, reset again during a write cycle
        sync_rst = 1'b1;
        repeat (2) @(negedge outclk);
        m_lfsr   = SEED;
        sync_rst = 1'b0;
        run_shuffle(1, 148);
        @(negedge outclk);
        check("held_rst_ready", 32'(deck_ready), 32'd0);
        check_deck("aborted");
        sync_rst = 1'b0;
        run_shuffle(1, -1);
        check_deck("rerun");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
